asmd_mult_sequencer: RTL and testbench

ASMD_MULT_SEQUENCER -- requirements
Module: asmd_mult_sequencer

---
 rtl/asmd_mult_sequencer.sv | 155 +++++++++++++++
 tb/tb_asmd_mult_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asmd_mult_sequencer.sv
// asmd_mult_sequencer
// Buffers operand pairs from an upstream producer in a small circular queue and
// hands them one at a time to an external ASMD multiplier using a start/ready
// handshake. Products come back through a single result register with a
// valid/ready interface, so results leave in the same order the pairs arrived.

module asmd_mult_sequencer #(
   parameter int word_length = 4,
   parameter int fifo_depth  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [word_length-1:0]           in_word0,
   input  logic [word_length-1:0]           in_word1,
   output logic                             mult_start,
   output logic [word_length-1:0]           mult_word0,
   output logic [word_length-1:0]           mult_word1,
   input  logic                             mult_ready,
   input  logic [2*word_length-1:0]         mult_product,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [2*word_length-1:0]         out_product,
   output logic [$clog2(fifo_depth+1)-1:0]  pending
);

   // The queue depth is a power of two, so the pointers wrap on their own.
   localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int cnt_w = $clog2(fifo_depth + 1);

   localparam logic [cnt_w-1:0] full_count = cnt_w'(fifo_depth);
   localparam logic [cnt_w-1:0] cnt_one    = cnt_w'(1);
   localparam logic [ptr_w-1:0] ptr_one    = ptr_w'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t state;

   // Operand storage; contents are only meaningful between wr_ptr and rd_ptr.
   logic [word_length-1:0] store_word0 [fifo_depth];
   logic [word_length-1:0] store_word1 [fifo_depth];

   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic [cnt_w-1:0] pending_next;

   logic push;
   logic issue;
   logic out_free;

   // A pair is accepted only when the registered ready flag is already high.
   assign push = in_valid & in_ready;

   // The result register is free if it is empty or is being emptied this edge.
   assign out_free = ~out_valid | out_ready;

   // A new multiply starts only from IDLE, with work queued, the multiplier
   // idle and somewhere for the product to land.
   assign issue = (state == IDLE) & (pending != '0) & mult_ready & out_free;

   // Next queue occupancy; a push and an issue on the same edge cancel out.
   always_comb begin
      pending_next = pending;
      if (push && !issue) begin
         pending_next = pending + cnt_one;
      end else if (!push && issue) begin
         pending_next = pending - cnt_one;
      end
   end

   // Operand storage writes; storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         store_word0[wr_ptr] <= in_word0;
         store_word1[wr_ptr] <= in_word1;
      end
   end

   // Queue pointers, occupancy and the registered ready flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pending  <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ptr_one;
         end
         if (issue) begin
            rd_ptr <= rd_ptr + ptr_one;
         end
         pending  <= pending_next;
         in_ready <= (pending_next != full_count);
      end
   end

   // Control FSM with registered start pulse, operand and result outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         mult_start  <= 1'b0;
         mult_word0  <= '0;
         mult_word1  <= '0;
         out_valid   <= 1'b0;
         out_product <= '0;
      end else begin
         mult_start <= 1'b0;

         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (issue) begin
                  mult_word0 <= store_word0[rd_ptr];
                  mult_word1 <= store_word1[rd_ptr];
                  mult_start <= 1'b1;
                  state      <= START;
               end
            end

            START: begin
               state <= WAIT_BUSY;
            end

            WAIT_BUSY: begin
               if (!mult_ready) begin
                  state <= WAIT_DONE;
               end
            end

            WAIT_DONE: begin
               if (mult_ready) begin
                  out_product <= mult_product;
                  out_valid   <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_asmd_mult_sequencer.sv
// tb_asmd_mult_sequencer
// Directed and random stimulus for asmd_mult_sequencer against a simple
// multiplier stand-in, with a transaction-level model of the queue and the
// result stream.

module tb_asmd_mult_sequencer;

   localparam int word_length = 4;
   localparam int fifo_depth  = 4;
   localparam int cnt_w       = $clog2(fifo_depth + 1);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_word0 = 4'd0;
   logic [3:0]       in_word1 = 4'd0;
   logic             mult_start;
   logic [3:0]       mult_word0;
   logic [3:0]       mult_word1;
   logic             mult_ready;
   logic [7:0]       mult_product = 8'd0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [7:0]       out_product;
   logic [cnt_w-1:0] pending;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   asmd_mult_sequencer #(
      .word_length(word_length),
      .fifo_depth (fifo_depth)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_word0    (in_word0),
      .in_word1    (in_word1),
      .mult_start  (mult_start),
      .mult_word0  (mult_word0),
      .mult_word1  (mult_word1),
      .mult_ready  (mult_ready),
      .mult_product(mult_product),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .pending     (pending)
   );

   // Multiplier stand-in: drops ready for mult_lat cycles after a start pulse.
   logic mult_busy = 1'b0;
   logic mult_hold = 1'b0;
   logic mult_rand_lat = 1'b0;
   int   mult_cnt = 0;
   int   mult_lat = 2;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mult_busy    <= 1'b0;
         mult_cnt     <= 0;
         mult_product <= 8'd0;
      end else if (mult_busy) begin
         if (mult_cnt <= 1) mult_busy <= 1'b0;
         else mult_cnt <= mult_cnt - 1;
      end else if (mult_start) begin
         mult_busy    <= 1'b1;
         mult_cnt     <= mult_rand_lat ? int'($urandom_range(1, 4)) : mult_lat;
         mult_product <= {4'd0, mult_word0} * {4'd0, mult_word1};
      end
   end

   assign mult_ready = ~mult_busy & ~mult_hold;

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] expected);
      checks++;
      if (got !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, expected, $time);
      end
   endtask

   // Transaction model: queue of accepted pairs, one operation in flight,
   // one result slot; predictions for the next edge are made each negedge.
   logic [3:0] q0[$];
   logic [3:0] q1[$];
   int         m_pending = 0;
   int         delivered = 0;
   logic       armed = 1'b0;
   logic       prev_high = 1'b0;
   logic       inflight = 1'b0;
   logic       saw_low = 1'b0;
   logic       cap_due = 1'b0;
   logic       exp_ov = 1'b0;
   logic       exp_issue = 1'b0;
   logic       exp_push = 1'b0;
   logic       prev_out_ready = 1'b0;
   logic [3:0] cur0 = 4'd0;
   logic [3:0] cur1 = 4'd0;
   logic [3:0] push_w0 = 4'd0;
   logic [3:0] push_w1 = 4'd0;
   logic [7:0] exp_prod = 8'd0;

   // Compare process: every negedge, advance the model past the last edge and check.
   always @(negedge clk) begin
      if (!reset) begin
         check_output("reset_in_ready",    32'(in_ready),    32'd0);
         check_output("reset_mult_start",  32'(mult_start),  32'd0);
         check_output("reset_mult_word0",  32'(mult_word0),  32'd0);
         check_output("reset_mult_word1",  32'(mult_word1),  32'd0);
         check_output("reset_out_valid",   32'(out_valid),   32'd0);
         check_output("reset_out_product", 32'(out_product), 32'd0);
         check_output("reset_pending",     32'(pending),     32'd0);
         q0.delete();
         q1.delete();
         m_pending = 0;
         inflight  = 1'b0;
         saw_low   = 1'b0;
         cap_due   = 1'b0;
         exp_ov    = 1'b0;
         exp_issue = 1'b0;
         exp_push  = 1'b0;
         prev_high = 1'b0;
      end else begin
         armed = prev_high;

         if (exp_issue) begin
            cur0 = q0.pop_front();
            cur1 = q1.pop_front();
            m_pending--;
            inflight = 1'b1;
            saw_low  = 1'b0;
         end
         if (exp_push) begin
            q0.push_back(push_w0);
            q1.push_back(push_w1);
            m_pending++;
         end
         if (cap_due) begin
            exp_ov   = 1'b1;
            exp_prod = {4'd0, cur0} * {4'd0, cur1};
            inflight = 1'b0;
            cap_due  = 1'b0;
         end else if (exp_ov && prev_out_ready) begin
            exp_ov = 1'b0;
         end

         check_output("in_ready",   32'(in_ready),   32'(armed && (m_pending != fifo_depth)));
         check_output("pending",    32'(pending),    32'(m_pending));
         check_output("mult_start", 32'(mult_start), 32'(exp_issue));
         if (mult_start) check_output("start_while_ready", 32'(mult_ready), 32'd1);
         if (inflight) check_output("mult_words", 32'({mult_word0, mult_word1}), 32'({cur0, cur1}));
         check_output("out_valid",  32'(out_valid),  32'(exp_ov));
         if (exp_ov) check_output("out_product", 32'(out_product), 32'(exp_prod));

         if (exp_ov && out_ready) delivered++;
         if (inflight && !exp_issue) begin
            if (!saw_low) begin
               if (!mult_ready) saw_low = 1'b1;
            end else if (mult_ready) begin
               cap_due = 1'b1;
            end
         end
         exp_issue = armed && !inflight && (m_pending > 0) && mult_ready && (!exp_ov || out_ready);
         exp_push  = in_valid && armed && (m_pending != fifo_depth);
         push_w0 = in_word0;
         push_w1 = in_word1;
         prev_out_ready = out_ready;
         prev_high = 1'b1;
      end
   end

   // Offer one pair and hold it until the sequencer takes it.
   task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_word0 = a;
      in_word1 = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_output("push_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait for the next result and compare it against a hand-computed value.
   task automatic wait_result(input logic [7:0] expected, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_valid"}, 32'(out_valid), 32'd1);
      check_output(name, 32'(out_product), 32'(expected));
   endtask

   // Watchdog so a stuck run still ends.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   logic rand_done = 1'b0;
   int   base;
   int   gap;
   int   wait_n;

   initial begin
      // Reset state and release.
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_pending_lit", 32'(pending), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_output("in_ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check_output("in_ready_after_edge", 32'(in_ready), 32'd1);

      // Basic product and single-cycle valid.
      apply_stimulus(4'd4, 4'd5);
      wait_result(8'h14, "basic_4x5");
      @(negedge clk);
      check_output("basic_single_cycle", 32'(out_valid), 32'd0);

      // Operand extremes.
      apply_stimulus(4'd15, 4'd15);
      wait_result(8'hE1, "max_15x15");
      apply_stimulus(4'd0, 4'd9);
      wait_result(8'h00, "zero_0x9");

      // Queue full with the multiplier held busy.
      @(posedge clk); #1;
      mult_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_word0 = 4'(2 * i + 1);
         in_word1 = 4'(2 * i + 2);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_output("full_pending", 32'(pending), 32'd4);
      check_output("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      mult_hold = 1'b0;
      wait_result(8'd2,  "drain_1x2");
      wait_result(8'd12, "drain_3x4");
      wait_result(8'd30, "drain_5x6");
      wait_result(8'd56, "drain_7x8");
      repeat (15) @(negedge clk);
      check_output("drain_empty", 32'(pending), 32'd0);

      // Backpressure on the result register.
      @(posedge clk); #1;
      out_ready = 1'b0;
      apply_stimulus(4'd2, 4'd3);
      apply_stimulus(4'd4, 4'd4);
      apply_stimulus(4'd5, 4'd3);
      wait_n = 0;
      @(negedge clk);
      while (!out_valid && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      for (int i = 0; i < 10; i++) begin
         check_output("bp_product", 32'(out_product), 32'd6);
         check_output("bp_pending", 32'(pending), 32'd2);
         check_output("bp_no_start", 32'(mult_start), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_result(8'd6,  "bp_2x3");
      wait_result(8'd16, "bp_4x4");
      wait_result(8'd15, "bp_5x3");

      // Reset while waiting on a slow multiply with three pairs queued.
      mult_lat = 20;
      apply_stimulus(4'd1, 4'd1);
      apply_stimulus(4'd2, 4'd2);
      apply_stimulus(4'd3, 4'd1);
      apply_stimulus(4'd6, 4'd7);
      @(negedge clk);
      check_output("pre_reset_pending", 32'(pending), 32'd3);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check_output("mid_reset_pending",   32'(pending),     32'd0);
      check_output("mid_reset_in_ready",  32'(in_ready),    32'd0);
      check_output("mid_reset_start",     32'(mult_start),  32'd0);
      check_output("mid_reset_words",     32'({mult_word0, mult_word1}), 32'd0);
      check_output("mid_reset_out_valid", 32'(out_valid),   32'd0);
      check_output("mid_reset_product",   32'(out_product), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      mult_lat = 2;
      apply_stimulus(4'd3, 4'd3);
      wait_result(8'd9, "post_reset_3x3");

      // Random traffic checked by the model.
      mult_rand_lat = 1'b1;
      base = delivered;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               gap = int'($urandom_range(0, 2));
               repeat (gap) @(posedge clk);
               apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            wait_n = 0;
            while ((delivered - base) < 200 && wait_n < 20000) begin
               @(negedge clk);
               wait_n++;
            end
            check_output("random_delivered", 32'(delivered - base), 32'd200);
            rand_done = 1'b1;
         end
      join
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check_output("final_pending", 32'(pending), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
